tone_sched: RTL and testbench
=============================

# tone_sched

Arbitrates the board's single speaker output among several tone requesters: the correct-entry indicator, the incorrect-entry indicator and the keypress click. Each requester pulses a request and supplies a tone half-period. The block queues requests, grants the speaker to one requester at a time (round-robin), plays a fixed-length square-wave burst, then inserts a silent gap before the next burst. It sits between the sequence-detector FSMs and the speaker pin.

## Interface
- NREQ, 3: number of requesters (2..8)
- HPW, 20: width of each half-period field in clock cycles
- DUR_CYC, 62500000: burst length in clk cycles (500 ms at 125 MHz); must be ≥1
- GAP_CYC, 1250000: silent gap after each burst (10 ms); 0 allowed
- clk  in  1  system clock, 125 MHz
- clr  in  1  synchronous reset, active-high
- req  in  NREQ  per-requester request; any cycle high queues one burst
- half_period  in  NREQ*HPW  flattened half-periods; field k = bits [k*HPW +: HPW]
- grant  out  NREQ  one-hot owner of the speaker, high for the whole PLAY state
- busy  out  1  high in PLAY or GAP
- done  out  NREQ  one-cycle pulse on the bit of the requester whose burst just ended
- toneout  out  1  speaker drive

## Operation
- pend[NREQ-1:0] register: bit k set on any edge with req[k]=1; cleared on the edge that grants k, unless req[k]=1 on that same edge (new request wins, bit stays set).
- States: IDLE, PLAY, GAP.
- IDLE: if pend≠0, select a winner, go to PLAY, set grant, latch hp=half_period field of the winner, zero hp_cnt/dur_cnt, toneout=0. Otherwise stay.
- Round-robin: search starts at last_grant+1 mod NREQ; after reset last_grant=NREQ-1, so index 0 wins first.
- PLAY: dur_cnt increments every cycle. hp_cnt increments; when hp_cnt==hp-1, toneout toggles and hp_cnt→0. A latched hp of 0 means silence: toneout held 0, duration still runs. On the cycle where dur_cnt==DUR_CYC-1: go to GAP (or IDLE if GAP_CYC=0), grant→0, done[winner] pulses, toneout→0.
- GAP: toneout=0, count GAP_CYC cycles, then IDLE.
- half_period changes during PLAY have no effect (latched value used).
- A requester may re-request during its own burst; it is queued and competes normally.
- Multiple simultaneous req bits all queue; order follows arbitration.

## Timing
- Reset values: grant=0, done=0, busy=0, toneout=0, pend=0, state=IDLE, last_grant=NREQ-1.
- clr mid-burst: all outputs at reset values after the clr edge; pending requests are discarded.
- Latency: req[k] high at edge t → pend[k]=1 after t → grant[k]=1, busy=1 after edge t+1 (IDLE, no other pending).
- First toneout rising edge: hp cycles after grant rises; period 2·hp cycles.
- grant high exactly DUR_CYC cycles; done pulse is coincident with the first cycle grant is low.
- Back-to-back: next grant rises GAP_CYC+1 cycles after done (GAP cycles plus one IDLE arbitration cycle).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- TONE_SCHED_PRIO_EN defined: fixed priority, lowest pending index always wins; last_grant unused.
- Undefined (default): round-robin as above.

## Test plan
Bench parameters: NREQ=3, HPW=8, DUR_CYC=20, GAP_CYC=4.
- Single request: req[1] pulse at t=0, hp1=3 → grant=3'b010 at t=2..21, toneout high at t=5..7, low 8..10, …; done=3'b010 at t=22; busy low from t=26.
- Simultaneous req=3'b111 once → grants in order 0,1,2, each 20 cycles, grant rises 5 cycles after each done; with TONE_SCHED_PRIO_EN the same order, but with req[0] re-pulsed during burst 1, 0 wins over 2.
- Round-robin fairness: req[0] and req[2] held high continuously → grants alternate 0,2,0,2.
- hp=0 → grant for 20 cycles, toneout stays 0, done still pulses.
- clr asserted at cycle 10 of a burst with req[2] pending → next cycle grant=0, toneout=0, busy=0; no later grant without a new req.
- req[0] re-pulsed on the same edge it is granted → second burst for 0 follows after the gap.

Source files
------------

// File: rtl/tone_sched.sv
// Speaker arbiter: queues tone requests, grants one requester at a time,
// plays a fixed-length square-wave burst, then holds a silent gap.
// Define TONE_SCHED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
//
// state  | meaning
// S_IDLE | waiting for a pending request; arbitrates when one exists
// S_PLAY | grant held, square wave driven from the latched half-period
// S_GAP  | speaker silent for GAP_CYC cycles before the next arbitration
module tone_sched #(
  parameter int NREQ    = 3,
  parameter int HPW     = 20,
  parameter int DUR_CYC = 62500000,
  parameter int GAP_CYC = 1250000
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*HPW-1:0] half_period,
  output logic [NREQ-1:0]     grant,
  output logic                busy,
  output logic [NREQ-1:0]     done,
  output logic                toneout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = (DUR_CYC > 1) ? $clog2(DUR_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DW-1:0] DUR_LAST = DW'(DUR_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [HPW-1:0]  hp_q, hp_d;
  logic [HPW-1:0]  hp_cnt_q, hp_cnt_d;
  logic [DW-1:0]   dur_cnt_q, dur_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            tone_q, tone_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [NREQ-1:0] pick_oh;

`ifndef TONE_SCHED_PRIO_EN
  logic [IW-1:0]   last_q, last_d;
  logic [IW:0]     rr_sum;
`endif

  // Arbitration over the pending set; later loop iterations take precedence.
  always_comb begin
    found = 1'b0;
    pick  = '0;
`ifdef TONE_SCHED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
`else
    rr_sum = '0;
    // Offset 1 from the last owner is tried last so it wins; offset NREQ is the last owner itself.
    for (int i = NREQ; i >= 1; i--) begin
      rr_sum = {1'b0, last_q} + (IW+1)'(i);
      if (rr_sum >= (IW+1)'(NREQ)) rr_sum = rr_sum - (IW+1)'(NREQ);
      if (pend_q[rr_sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = rr_sum[IW-1:0];
      end
    end
`endif
  end

  assign pick_oh = NREQ'(1) << pick;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (found) state_d = S_PLAY;
      S_PLAY: if (dur_cnt_q == DUR_LAST) state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_d    = pend_q | req;
    hp_d      = hp_q;
    hp_cnt_d  = hp_cnt_q;
    dur_cnt_d = dur_cnt_q;
    gap_cnt_d = gap_cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    tone_d    = tone_q;
`ifndef TONE_SCHED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        if (found) begin
          // A request arriving on the granting edge keeps the bit set.
          pend_d    = (pend_q & ~pick_oh) | req;
          grant_d   = pick_oh;
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
`ifndef TONE_SCHED_PRIO_EN
          last_d    = pick;
`endif
          for (int k = 0; k < NREQ; k++) begin
            if (pick == IW'(k)) hp_d = half_period[k*HPW +: HPW];
          end
        end
      end
      S_PLAY: begin
        dur_cnt_d = dur_cnt_q + DW'(1);
        if (hp_q == '0) begin
          tone_d   = 1'b0;
          hp_cnt_d = '0;
        end else if (hp_cnt_q == hp_q - HPW'(1)) begin
          tone_d   = ~tone_q;
          hp_cnt_d = '0;
        end else begin
          hp_cnt_d = hp_cnt_q + HPW'(1);
        end
        if (dur_cnt_q == DUR_LAST) begin
          grant_d   = '0;
          done_d    = grant_q;
          tone_d    = 1'b0;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        tone_d    = 1'b0;
        gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: begin
        grant_d = '0;
        tone_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pend_q    <= '0;
      hp_q      <= '0;
      hp_cnt_q  <= '0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      tone_q    <= 1'b0;
`ifndef TONE_SCHED_PRIO_EN
      last_q    <= IW'(NREQ - 1);
`endif
    end else begin
      pend_q    <= pend_d;
      hp_q      <= hp_d;
      hp_cnt_q  <= hp_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tone_q    <= tone_d;
`ifndef TONE_SCHED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign toneout = tone_q;

endmodule

// File: tb/tb_tone_sched.sv
// Directed bench for tone_sched: a per-cycle vector table for a single burst,
// plus hand sequences for arbitration order, hp=0, clr mid-burst and re-requests.
module tb_tone_sched;

  localparam int NREQ = 3;
  localparam int HPW  = 8;
  localparam int DUR  = 20;
  localparam int GAP  = 4;
  localparam int NROW = 27;

  logic                clk = 1'b0;
  logic                clr = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*HPW-1:0] half_period = '0;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic [NREQ-1:0]     done;
  logic                toneout;

  int total = 0;
  int bad   = 0;

  tone_sched #(.NREQ(NREQ), .HPW(HPW), .DUR_CYC(DUR), .GAP_CYC(GAP)) dut (
    .clk(clk), .clr(clr), .req(req), .half_period(half_period),
    .grant(grant), .busy(busy), .done(done), .toneout(toneout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [23:0] hp;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        busy;
    logic        tone;
  } vec_t;

  vec_t tbl[NROW];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    req = '0;
    step();
    step();
    clr = 1'b0;
  endtask

  // Waits for grant to rise, checks owner, length, done pulse; optionally pulses req mid-burst.
  task automatic burst(input string nm, input logic [2:0] exp_g, input int exp_wait,
                       input logic [2:0] pulse_req, input int pulse_at, output bit any_tone);
    int n;
    int len;
    bit run;
    n = 0;
    while (grant == 3'b000 && n < 200) begin
      step();
      n++;
    end
    chk({nm, "_wait"}, n, exp_wait);
    chk({nm, "_grant"}, 32'(grant), 32'(exp_g));
    len = 1;
    any_tone = toneout;
    run = 1'b1;
    while (run) begin
      if (len == pulse_at) req = pulse_req;
      step();
      if (len == pulse_at) req = 3'b000;
      if (grant !== exp_g || len >= 200) run = 1'b0;
      else begin
        len++;
        any_tone |= toneout;
      end
    end
    chk({nm, "_len"}, len, DUR);
    chk({nm, "_done"}, 32'(done), 32'(exp_g));
    chk({nm, "_gfall"}, 32'(grant), 32'(0));
  endtask

  initial begin
    bit tn;
    int n;
    step();
    step();
    clr = 1'b0;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tone", 32'(toneout), 0);

    // Row r: inputs driven before edge r, outputs expected after edge r.
    // hp1=3 latched at edge 1; later half_period changes must not matter.
    for (int r = 0; r < NROW; r++) begin
      tbl[r].req   = (r == 0) ? 3'b010 : 3'b000;
      tbl[r].hp    = (r < 3) ? 24'h000300 : 24'h070509;
      tbl[r].grant = (r >= 1 && r <= 20) ? 3'b010 : 3'b000;
      tbl[r].done  = (r == 21) ? 3'b010 : 3'b000;
      tbl[r].busy  = (r >= 1 && r <= 24);
      tbl[r].tone  = (r >= 1 && r <= 20) && ((((r - 1) / 3) % 2) == 1);
    end
    for (int r = 0; r < NROW; r++) begin
      req = tbl[r].req;
      half_period = tbl[r].hp;
      step();
      chk($sformatf("tbl%0d_grant", r), 32'(grant), 32'(tbl[r].grant));
      chk($sformatf("tbl%0d_done", r), 32'(done), 32'(tbl[r].done));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
      chk($sformatf("tbl%0d_tone", r), 32'(toneout), 32'(tbl[r].tone));
    end

    // All three request at once; req[0] re-pulsed during burst of 1.
    do_clr();
    half_period = {8'd2, 8'd2, 8'd2};
    req = 3'b111;
    step();
    req = 3'b000;
    burst("sim_b0", 3'b001, 1, 3'b000, -1, tn);
    chk("sim_b0_tone", 32'(tn), 1);
    burst("sim_b1", 3'b010, 5, 3'b001, 6, tn);
`ifdef TONE_SCHED_PRIO_EN
    burst("sim_b2", 3'b001, 5, 3'b000, -1, tn);
    burst("sim_b3", 3'b100, 5, 3'b000, -1, tn);
`else
    burst("sim_b2", 3'b100, 5, 3'b000, -1, tn);
    burst("sim_b3", 3'b001, 5, 3'b000, -1, tn);
`endif
    step();
    step();
    step();
    chk("sim_gap_busy", 32'(busy), 1);
    step();
    chk("sim_idle_busy", 32'(busy), 0);

    // Fairness: req[0] and req[2] held high.
    do_clr();
    req = 3'b101;
    step();
    burst("rr_b0", 3'b001, 1, 3'b000, -1, tn);
`ifdef TONE_SCHED_PRIO_EN
    burst("rr_b1", 3'b001, 5, 3'b000, -1, tn);
    burst("rr_b2", 3'b001, 5, 3'b000, -1, tn);
    burst("rr_b3", 3'b001, 5, 3'b000, -1, tn);
`else
    burst("rr_b1", 3'b100, 5, 3'b000, -1, tn);
    burst("rr_b2", 3'b001, 5, 3'b000, -1, tn);
    burst("rr_b3", 3'b100, 5, 3'b000, -1, tn);
`endif
    req = 3'b000;

    // Half-period of zero: silent burst, done still pulses.
    do_clr();
    half_period = {8'd0, 8'd5, 8'd5};
    req = 3'b100;
    step();
    req = 3'b000;
    burst("hp0", 3'b100, 1, 3'b000, -1, tn);
    chk("hp0_tone", 32'(tn), 0);

    // clr at cycle 10 of a burst with req[2] queued.
    do_clr();
    half_period = {8'd3, 8'd3, 8'd3};
    req = 3'b101;
    step();
    req = 3'b000;
    n = 0;
    while (grant == 3'b000 && n < 50) begin
      step();
      n++;
    end
    chk("clr_g0", 32'(grant), 32'(3'b001));
    repeat (9) step();
    chk("clr_pre_busy", 32'(busy), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_grant", 32'(grant), 0);
    chk("clr_tone", 32'(toneout), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_done", 32'(done), 0);
    n = 0;
    repeat (60) begin
      step();
      if (grant != 3'b000) n++;
    end
    chk("clr_no_regrant", n, 0);

    // req[0] held through the granting edge queues a second burst.
    do_clr();
    req = 3'b001;
    step();
    step();
    req = 3'b000;
    burst("same_b0", 3'b001, 0, 3'b000, -1, tn);
    burst("same_b1", 3'b001, 5, 3'b000, -1, tn);
    n = 0;
    repeat (40) begin
      step();
      if (grant != 3'b000) n++;
    end
    chk("same_no_third", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
